alu_cmd_driver: RTL and testbench

- Initiator side of the simple_alu serial-opcode interface: accepts one parallel command (opcode, operand A, operand B) and serializes it onto opcode_valid/opcode/data.
- Waits for done, then returns result/overflow as a single-cycle response.
- Owns the ALU's active-low reset and sits between a command source (sequencer or CPU model) and simple_alu; alu_chkr can monitor the same wires.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_serializer.sv | 60 ++++++
 rtl/alu_cmd_driver.sv | 153 +++++++++++++++
 tb/tb_alu_cmd_driver.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and defaults for the simple_alu command driver and its serializer.
package alu_pkg;

    localparam int unsigned ALU_DATA_WIDTH   = 8;
    localparam int unsigned ALU_OPCODE_WIDTH = 3;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } alu_op_e;

    typedef enum logic [2:0] {
        ALU_RST,
        IDLE,
        SEND,
        WAIT,
        RESP
    } drv_state_e;

    typedef struct packed {
        logic [ALU_DATA_WIDTH-1:0] result;
        logic                      overflow;
        logic                      timeout;
    } rsp_t;

endpackage

// File: rtl/alu_serializer.sv
// Shifts a latched command out as an LSB-first opcode frame with A, then B, on the data bus.
module alu_serializer
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = ALU_DATA_WIDTH,
    parameter int unsigned OPCODE_WIDTH = ALU_OPCODE_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [OPCODE_WIDTH-1:0] op_in,
    input  logic [DATA_WIDTH-1:0]   a_in,
    input  logic [DATA_WIDTH-1:0]   b_in,
    output logic                    opcode_valid,
    output logic                    opcode,
    output logic [DATA_WIDTH-1:0]   data,
    output logic                    last_bit
);

    localparam int unsigned CNT_W = (OPCODE_WIDTH > 1) ? $clog2(OPCODE_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(OPCODE_WIDTH - 1);

    logic [CNT_W-1:0]        bit_cnt;
    logic [OPCODE_WIDTH-1:0] op_sr;
    logic [DATA_WIDTH-1:0]   b_q;

    assign last_bit = opcode_valid && (bit_cnt == LAST_IDX);

    // Bit 0 and operand A are loaded on the start edge so the frame begins the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode_valid <= 1'b0;
            opcode       <= 1'b0;
            data         <= '0;
            bit_cnt      <= '0;
            op_sr        <= '0;
            b_q          <= '0;
        end else if (start) begin
            opcode_valid <= 1'b1;
            opcode       <= op_in[0];
            op_sr        <= op_in >> 1;
            data         <= a_in;
            b_q          <= b_in;
            bit_cnt      <= '0;
        end else if (opcode_valid) begin
            if (bit_cnt == LAST_IDX) begin
                opcode_valid <= 1'b0;
                opcode       <= 1'b0;
                data         <= '0;
                bit_cnt      <= '0;
            end else begin
                opcode  <= op_sr[0];
                op_sr   <= op_sr >> 1;
                data    <= (bit_cnt == '0) ? b_q : '0;
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// Initiator for the simple_alu serial-opcode interface: ALU reset, command serialization,
// done/timeout wait and single-cycle response.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = ALU_DATA_WIDTH,
    parameter int unsigned OPCODE_WIDTH   = ALU_OPCODE_WIDTH,
    parameter int unsigned ALU_RST_CYCLES = 4,
    parameter int unsigned TIMEOUT        = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [OPCODE_WIDTH-1:0] cmd_opcode,
    input  logic [DATA_WIDTH-1:0]   cmd_a,
    input  logic [DATA_WIDTH-1:0]   cmd_b,
    output logic                    alu_reset_n,
    output logic                    opcode_valid,
    output logic                    opcode,
    output logic [DATA_WIDTH-1:0]   data,
    input  logic                    done,
    input  logic [DATA_WIDTH-1:0]   result,
    input  logic                    overflow,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_result,
    output logic                    rsp_overflow,
    output logic                    rsp_timeout,
    output logic                    busy
);

    localparam int unsigned RST_CW  = $clog2(ALU_RST_CYCLES + 1);
    localparam int unsigned WAIT_CW = $clog2(TIMEOUT + 1);

    drv_state_e             state, state_d;
    logic [RST_CW-1:0]      rst_cnt, rst_cnt_d;
    logic [WAIT_CW-1:0]     wait_cnt, wait_cnt_d;
    logic                   cmd_ready_d, busy_d, alu_reset_n_d;
    logic                   rsp_valid_d, rsp_overflow_d, rsp_timeout_d;
    logic [DATA_WIDTH-1:0]  rsp_result_d;
    logic                   start, last_bit;

    alu_serializer #(
        .DATA_WIDTH   (DATA_WIDTH),
        .OPCODE_WIDTH (OPCODE_WIDTH)
    ) u_serializer (
        .clk          (clk),
        .rst          (reset),
        .start        (start),
        .op_in        (cmd_opcode),
        .a_in         (cmd_a),
        .b_in         (cmd_b),
        .opcode_valid (opcode_valid),
        .opcode       (opcode),
        .data         (data),
        .last_bit     (last_bit)
    );

    always_comb begin
        state_d        = state;
        rst_cnt_d      = rst_cnt;
        wait_cnt_d     = wait_cnt;
        cmd_ready_d    = 1'b0;
        busy_d         = busy;
        alu_reset_n_d  = alu_reset_n;
        rsp_valid_d    = 1'b0;
        rsp_result_d   = rsp_result;
        rsp_overflow_d = rsp_overflow;
        rsp_timeout_d  = rsp_timeout;
        start          = 1'b0;
        case (state)
            ALU_RST: begin
                if (rst_cnt == RST_CW'(ALU_RST_CYCLES)) begin
                    state_d       = IDLE;
                    alu_reset_n_d = 1'b1;
                    rst_cnt_d     = '0;
                end else begin
                    rst_cnt_d = rst_cnt + 1'b1;
                end
            end
            IDLE: begin
                busy_d      = 1'b0;
                cmd_ready_d = 1'b1;
                // cmd_ready is registered, so it is the accept qualifier seen by the source.
                if (cmd_valid && cmd_ready) begin
                    start       = 1'b1;
                    state_d     = SEND;
                    busy_d      = 1'b1;
                    cmd_ready_d = 1'b0;
                end
            end
            SEND: begin
                if (last_bit) begin
                    state_d    = WAIT;
                    wait_cnt_d = WAIT_CW'(1);
                end
            end
            WAIT: begin
                // done takes priority over an expiring count in the same cycle.
                if (done) begin
                    state_d        = RESP;
                    rsp_valid_d    = 1'b1;
                    rsp_result_d   = result;
                    rsp_overflow_d = overflow;
                    rsp_timeout_d  = 1'b0;
                end else if (wait_cnt == WAIT_CW'(TIMEOUT)) begin
                    state_d        = RESP;
                    rsp_valid_d    = 1'b1;
                    rsp_result_d   = '0;
                    rsp_overflow_d = 1'b0;
                    rsp_timeout_d  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt + 1'b1;
                end
            end
            RESP: begin
                state_d    = IDLE;
                busy_d     = 1'b0;
                wait_cnt_d = '0;
            end
            default: begin
                state_d = ALU_RST;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ALU_RST;
            rst_cnt      <= '0;
            wait_cnt     <= '0;
            cmd_ready    <= 1'b0;
            busy         <= 1'b0;
            alu_reset_n  <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_timeout  <= 1'b0;
        end else begin
            state        <= state_d;
            rst_cnt      <= rst_cnt_d;
            wait_cnt     <= wait_cnt_d;
            cmd_ready    <= cmd_ready_d;
            busy         <= busy_d;
            alu_reset_n  <= alu_reset_n_d;
            rsp_valid    <= rsp_valid_d;
            rsp_result   <= rsp_result_d;
            rsp_overflow <= rsp_overflow_d;
            rsp_timeout  <= rsp_timeout_d;
        end
    end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver: reset release, table of single commands, back-to-back, mid-frame reset.
module tb_alu_cmd_driver;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_opcode = '0;
    logic [7:0] cmd_a = '0;
    logic [7:0] cmd_b = '0;
    logic       alu_reset_n;
    logic       opcode_valid;
    logic       opcode;
    logic [7:0] data;
    logic       done = 1'b0;
    logic [7:0] result = '0;
    logic       overflow = 1'b0;
    logic       rsp_valid;
    logic [7:0] rsp_result;
    logic       rsp_overflow;
    logic       rsp_timeout;
    logic       busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_cmd_driver #(
        .DATA_WIDTH     (8),
        .OPCODE_WIDTH   (3),
        .ALU_RST_CYCLES (4),
        .TIMEOUT        (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_opcode   (cmd_opcode),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .alu_reset_n  (alu_reset_n),
        .opcode_valid (opcode_valid),
        .opcode       (opcode),
        .data         (data),
        .done         (done),
        .result       (result),
        .overflow     (overflow),
        .rsp_valid    (rsp_valid),
        .rsp_result   (rsp_result),
        .rsp_overflow (rsp_overflow),
        .rsp_timeout  (rsp_timeout),
        .busy         (busy)
    );

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        int         done_at;      // wait cycle in which the ALU raises done; 0 = never
        logic       done_in_send; // spurious done while the frame is on the wire
        logic [7:0] alu_res;
        logic       alu_ovf;
        rsp_t       exp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic release_seq();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("rstn_low", alu_reset_n, 0);
            check("rst_no_ready", cmd_ready, 0);
            check("rst_no_rsp", rsp_valid, 0);
        end
        @(negedge clk);
        check("rstn_high", alu_reset_n, 1);
        check("ready_lag", cmd_ready, 0);
        @(negedge clk);
        check("ready_up", cmd_ready, 1);
        check("rsp_result_rst", rsp_result, 0);
        check("rsp_ovf_rst", rsp_overflow, 0);
        check("rsp_to_rst", rsp_timeout, 0);
        check("busy_rst", busy, 0);
    endtask

    task automatic run_cmd(input vec_t v);
        logic [7:0] exp_d;
        int         exp_n;
        int         seen;
        int         i;
        for (i = 0; i < 40 && !cmd_ready; i++) @(negedge clk);
        check("ready_wait", cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_opcode = v.op;
        cmd_a      = v.a;
        cmd_b      = v.b;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            exp_d = (k == 0) ? v.a : (k == 1) ? v.b : 8'h00;
            check("frame_valid", opcode_valid, 1);
            check("frame_bit", opcode, v.op[k]);
            check("frame_data", data, exp_d);
            check("busy_send", busy, 1);
            if (v.done_in_send) begin
                done     = 1'b1;
                result   = 8'hEE;
                overflow = 1'b1;
            end
        end
        exp_n = (v.done_at != 0) ? v.done_at + 1 : 17;
        seen  = 0;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check("frame_end_valid", opcode_valid, 0);
                check("frame_end_data", data, 0);
            end
            done     = (n == v.done_at);
            result   = (n == v.done_at) ? v.alu_res : 8'h00;
            overflow = (n == v.done_at) ? v.alu_ovf : 1'b0;
            if (rsp_valid) begin
                seen = n;
                break;
            end
        end
        done = 1'b0;
        check("rsp_cycle", seen, exp_n);
        check("rsp_result", rsp_result, v.exp.result);
        check("rsp_overflow", rsp_overflow, v.exp.overflow);
        check("rsp_timeout", rsp_timeout, v.exp.timeout);
        @(negedge clk);
        check("rsp_one_cycle", rsp_valid, 0);
        check("rsp_hold", rsp_result, v.exp.result);
        check("busy_after", busy, 0);
    endtask

    // Back-to-back command set; expected responses are the sums computed by hand.
    logic [2:0] bb_op[4]  = '{3'b001, 3'b010, 3'b101, 3'b110};
    logic [7:0] bb_a[4]   = '{8'h10, 8'hF0, 8'h7F, 8'hC8};
    logic [7:0] bb_b[4]   = '{8'h20, 8'h20, 8'h01, 8'h64};
    logic [7:0] bb_res[4] = '{8'h30, 8'h10, 8'h80, 8'h2C};
    logic       bb_ovf[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{op: 3'b001, a: 8'h05, b: 8'h03, done_at: 1, done_in_send: 1'b0,
                    alu_res: 8'h08, alu_ovf: 1'b0, exp: '{result: 8'h08, overflow: 1'b0, timeout: 1'b0}};
        vecs[1] = '{op: OP_ADD, a: 8'hFF, b: 8'h01, done_at: 3, done_in_send: 1'b0,
                    alu_res: 8'h00, alu_ovf: 1'b1, exp: '{result: 8'h00, overflow: 1'b1, timeout: 1'b0}};
        vecs[2] = '{op: OP_SUB, a: 8'h10, b: 8'h20, done_at: 5, done_in_send: 1'b1,
                    alu_res: 8'hF0, alu_ovf: 1'b1, exp: '{result: 8'hF0, overflow: 1'b1, timeout: 1'b0}};
        vecs[3] = '{op: OP_XOR, a: 8'hA5, b: 8'h5A, done_at: 0, done_in_send: 1'b0,
                    alu_res: 8'h77, alu_ovf: 1'b1, exp: '{result: 8'h00, overflow: 1'b0, timeout: 1'b1}};
        vecs[4] = '{op: OP_AND, a: 8'h3C, b: 8'h0F, done_at: 16, done_in_send: 1'b0,
                    alu_res: 8'h0C, alu_ovf: 1'b0, exp: '{result: 8'h0C, overflow: 1'b0, timeout: 1'b0}};
        vecs[5] = '{op: OP_SHR, a: 8'h80, b: 8'h7F, done_at: 15, done_in_send: 1'b0,
                    alu_res: 8'hAB, alu_ovf: 1'b0, exp: '{result: 8'hAB, overflow: 1'b0, timeout: 1'b0}};

        // Reset state and release sequence
        @(negedge clk);
        @(negedge clk);
        check("reset_rstn", alu_reset_n, 0);
        check("reset_ready", cmd_ready, 0);
        check("reset_ov", opcode_valid, 0);
        check("reset_data", data, 0);
        check("reset_rsp", rsp_valid, 0);
        check("reset_busy", busy, 0);
        reset = 1'b0;
        release_seq();

        foreach (vecs[i]) run_cmd(vecs[i]);

        // done while idle must be ignored
        done     = 1'b1;
        result   = 8'hEE;
        overflow = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_done_rsp", rsp_valid, 0);
            check("idle_done_hold", rsp_result, 8'hAB);
            check("idle_done_busy", busy, 0);
        end
        done     = 1'b0;
        result   = 8'h00;
        overflow = 1'b0;

        // Back-to-back with cmd_valid held and a 2-cycle adder ALU model
        begin
            int         idx = 0, acc = 0, rsp_idx = 0, pos = 0, frame_idx = 0;
            int         done_timer = 0, overlap = 0;
            bit         pending = 0, prev_ov = 0;
            logic [7:0] cap_op = '0, cap_a = '0, cap_b = '0;
            logic [8:0] sum;
            for (int i = 0; i < 40 && !cmd_ready; i++) @(negedge clk);
            cmd_valid  = 1'b1;
            cmd_opcode = bb_op[0];
            cmd_a      = bb_a[0];
            cmd_b      = bb_b[0];
            pending    = cmd_ready;
            for (int cyc = 0; cyc < 300 && rsp_idx < 4; cyc++) begin
                @(negedge clk);
                if (pending) begin
                    acc++;
                    idx++;
                    pending = 0;
                    if (idx < 4) begin
                        cmd_opcode = bb_op[idx];
                        cmd_a      = bb_a[idx];
                        cmd_b      = bb_b[idx];
                    end else begin
                        cmd_valid = 1'b0;
                    end
                end
                if (cmd_valid && cmd_ready) pending = 1;
                if (cmd_ready && busy) overlap++;
                done = 1'b0;
                if (done_timer == 1) begin
                    sum      = {1'b0, cap_a} + {1'b0, cap_b};
                    done     = 1'b1;
                    result   = sum[7:0];
                    overflow = sum[8];
                end
                if (done_timer > 0) done_timer--;
                if (opcode_valid) begin
                    if (pos < 8) cap_op[pos] = opcode;
                    if (pos == 0) cap_a = data;
                    if (pos == 1) cap_b = data;
                    pos++;
                end else if (prev_ov) begin
                    check("bb_frame_len", pos, 3);
                    if (frame_idx < 4) begin
                        check("bb_frame_op", cap_op[2:0], bb_op[frame_idx]);
                        check("bb_frame_a", cap_a, bb_a[frame_idx]);
                        check("bb_frame_b", cap_b, bb_b[frame_idx]);
                    end
                    frame_idx++;
                    pos        = 0;
                    done_timer = 2;
                end
                prev_ov = opcode_valid;
                if (rsp_valid) begin
                    check("bb_rsp_result", rsp_result, bb_res[rsp_idx]);
                    check("bb_rsp_ovf", rsp_overflow, bb_ovf[rsp_idx]);
                    check("bb_rsp_to", rsp_timeout, 0);
                    rsp_idx++;
                end
            end
            done     = 1'b0;
            cmd_valid = 1'b0;
            check("bb_rsp_count", rsp_idx, 4);
            check("bb_accept_count", acc, 4);
            check("bb_frame_count", frame_idx, 4);
            check("bb_ready_while_busy", overlap, 0);
        end

        // Reset during bit 1 of a frame
        for (int i = 0; i < 40 && !cmd_ready; i++) @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_opcode = 3'b110;
        cmd_a      = 8'h11;
        cmd_b      = 8'h22;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("mid_bit0_valid", opcode_valid, 1);
        @(negedge clk);
        check("mid_bit1_bit", opcode, 1);
        check("mid_bit1_data", data, 8'h22);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_ov", opcode_valid, 0);
        check("mid_rst_rstn", alu_reset_n, 0);
        check("mid_rst_data", data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rsp", rsp_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        release_seq();
        run_cmd(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
